// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between the IF and DM requesters.
// Optional round-robin conflict resolution is enabled by defining MEM_ARB_RR_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              flush_i,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [31:0]       stall_cnt_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_DM = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 0: IF, 1: DM
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic if_elig;
  logic dm_elig;
  logic grant_dm;

  assign if_elig = if_req_i & ~flush_i;
  assign dm_elig = dm_req_i;

`ifdef MEM_ARB_RR_EN
  // On conflict, DM wins only if IF was granted last.
  assign grant_dm = dm_elig & (~if_elig | ~last_grant_q);
`else
  assign grant_dm = dm_elig;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          mem_req_d    = 1'b1;
          mem_we_d     = dm_we_i;
          mem_addr_d   = dm_addr_i;
          mem_wdata_d  = dm_wdata_i;
          last_grant_d = 1'b1;
          state_d      = BUSY_DM;
        end else if (if_elig) begin
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr_i;
          last_grant_d = 1'b0;
          state_d      = BUSY_IF;
        end
      end
      BUSY_IF: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!flush_i) begin
            if_rdata_d = mem_rdata_i;
            if_ready_d = 1'b1;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      BUSY_DM: begin
        if (mem_ack_i) begin
          mem_req_d  = 1'b0;
          dm_rdata_d = mem_rdata_i;
          dm_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      DRAIN: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_o = (if_req_i & ~if_ready_q & ~flush_i) | (dm_req_i & ~dm_ready_q);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ready_o  = if_ready_q;
  assign dm_ready_o  = dm_ready_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table plus hand-written corner sequences.
// Defining MEM_ARB_RR_EN switches the conflict expectation to round-robin.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req_i, flush_i, dm_req_i, dm_we_i, mem_ack_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o, stall_cnt_o;
  logic        if_ready_o, dm_ready_o, mem_req_o, mem_we_o, stall_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_ifrd;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .if_ready_o (if_ready_o),
    .flush_i    (flush_i),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_rdata_o (dm_rdata_o),
    .dm_ready_o (dm_ready_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .stall_o    (stall_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        fl;
    logic        dmr;
    logic        we;
    logic [31:0] dma;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rd;
    logic        x_stall;
    logic        x_req;
    logic        x_we;
    logic [31:0] x_addr;
    logic        x_ifrdy;
    logic [31:0] x_ifrd;
    logic        x_dmrdy;
    logic [31:0] x_dmrd;
    logic [31:0] x_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = 32'h0;
    flush_i     = 1'b0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_addr_i   = 32'h0;
    dm_wdata_i  = 32'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
  endtask

  initial begin
    // IF-only access, then DM/IF conflict, then IF blocked by flush in IDLE.
    vecs[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'd1};
    vecs[1] = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2010_0005,
                1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 32'h2010_0005, 1'b0, 32'h0, 32'd2};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 32'h2010_0005, 1'b0, 32'h0, 32'd2};
    vecs[3] = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0,
                1'b1, 1'b1, 1'b0, 32'h08, 1'b0, 32'h2010_0005, 1'b0, 32'h0, 32'd3};
    vecs[4] = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 32'h08, 32'h0, 1'b1, 32'hAAAA_0001,
                1'b1, 1'b0, 1'b0, 32'h08, 1'b0, 32'h2010_0005, 1'b1, 32'hAAAA_0001, 32'd4};
    vecs[5] = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b1, 1'b1, 1'b0, 32'h44, 1'b0, 32'h2010_0005, 1'b0, 32'hAAAA_0001, 32'd5};
    vecs[6] = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBBBB_0002,
                1'b1, 1'b0, 1'b0, 32'h44, 1'b1, 32'hBBBB_0002, 1'b0, 32'hAAAA_0001, 32'd6};
    vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h44, 1'b0, 32'hBBBB_0002, 1'b0, 32'hAAAA_0001, 32'd6};
    vecs[8] = '{1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h44, 1'b0, 32'hBBBB_0002, 1'b0, 32'hAAAA_0001, 32'd6};

    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_req", 32'(mem_req_o), 32'd0);
    chk("reset mem_addr", mem_addr_o, 32'h0);
    chk("reset if_ready", 32'(if_ready_o), 32'd0);
    chk("reset dm_ready", 32'(dm_ready_o), 32'd0);
    chk("reset stall_cnt", stall_cnt_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      if_req_i    = vecs[i].ifr;
      if_addr_i   = vecs[i].ifa;
      flush_i     = vecs[i].fl;
      dm_req_i    = vecs[i].dmr;
      dm_we_i     = vecs[i].we;
      dm_addr_i   = vecs[i].dma;
      dm_wdata_i  = vecs[i].wd;
      mem_ack_i   = vecs[i].ack;
      mem_rdata_i = vecs[i].rd;
      #1;
      chk($sformatf("v%0d stall", i), 32'(stall_o), 32'(vecs[i].x_stall));
      step();
      chk($sformatf("v%0d mem_req", i), 32'(mem_req_o), 32'(vecs[i].x_req));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we_o), 32'(vecs[i].x_we));
      chk($sformatf("v%0d mem_addr", i), mem_addr_o, vecs[i].x_addr);
      chk($sformatf("v%0d if_ready", i), 32'(if_ready_o), 32'(vecs[i].x_ifrdy));
      chk($sformatf("v%0d if_rdata", i), if_rdata_o, vecs[i].x_ifrd);
      chk($sformatf("v%0d dm_ready", i), 32'(dm_ready_o), 32'(vecs[i].x_dmrdy));
      chk($sformatf("v%0d dm_rdata", i), dm_rdata_o, vecs[i].x_dmrd);
      chk($sformatf("v%0d stall_cnt", i), stall_cnt_o, vecs[i].x_cnt);
    end
    clear_inputs();
    exp_ifrd = 32'hBBBB_0002;

    // Second conflict: DM re-requests during its own ready cycle while IF waits.
    if_req_i  = 1'b1;
    if_addr_i = 32'h50;
    dm_req_i  = 1'b1;
    dm_addr_i = 32'h10;
    step();
    chk("conf1 grant", mem_addr_o, 32'h10);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h11;
    step();
    chk("conf1 dm_ready", 32'(dm_ready_o), 32'd1);
    dm_addr_i = 32'h14;
    mem_ack_i = 1'b0;
    step();
`ifdef MEM_ARB_RR_EN
    chk("conf2 grant", mem_addr_o, 32'h50);
    exp_ifrd = 32'h22;
`else
    chk("conf2 grant", mem_addr_o, 32'h14);
`endif
    chk("conf2 mem_req", 32'(mem_req_o), 32'd1);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h22;
    step();
    clear_inputs();
    step();
    chk("conf2 if_rdata", if_rdata_o, exp_ifrd);

    // DM write with ack delayed three cycles.
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_addr_i  = 32'h0;
    dm_wdata_i = 32'h5;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr c%0d mem_req", i), 32'(mem_req_o), 32'd1);
      chk($sformatf("wr c%0d mem_we", i), 32'(mem_we_o), 32'd1);
      chk($sformatf("wr c%0d addr", i), mem_addr_o, 32'h0);
      chk($sformatf("wr c%0d wdata", i), mem_wdata_o, 32'h5);
      chk($sformatf("wr c%0d stall", i), 32'(stall_o), 32'd1);
      chk($sformatf("wr c%0d dm_ready", i), 32'(dm_ready_o), 32'd0);
      mem_ack_i = (i == 3);
      step();
    end
    chk("wr done dm_ready", 32'(dm_ready_o), 32'd1);
    chk("wr done mem_req", 32'(mem_req_o), 32'd0);
    clear_inputs();
    step();
    chk("wr pulse end", 32'(dm_ready_o), 32'd0);

    // Flush while IF is in flight, with a DM request pending.
    if_req_i  = 1'b1;
    if_addr_i = 32'h80;
    step();
    chk("fl grant addr", mem_addr_o, 32'h80);
    flush_i   = 1'b1;
    dm_req_i  = 1'b1;
    dm_addr_i = 32'hC0;
    step();
    chk("fl drain mem_req", 32'(mem_req_o), 32'd1);
    chk("fl drain if_ready", 32'(if_ready_o), 32'd0);
    flush_i     = 1'b0;
    if_req_i    = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEAD_0000;
    step();
    chk("fl idle mem_req", 32'(mem_req_o), 32'd0);
    chk("fl idle if_ready", 32'(if_ready_o), 32'd0);
    chk("fl if_rdata kept", if_rdata_o, exp_ifrd);
    mem_ack_i = 1'b0;
    step();
    chk("fl dm grant req", 32'(mem_req_o), 32'd1);
    chk("fl dm grant addr", mem_addr_o, 32'hC0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h33;
    step();
    chk("fl dm rdata", dm_rdata_o, 32'h33);
    clear_inputs();
    step();

    // Asynchronous reset in the middle of a DM access.
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_addr_i  = 32'h24;
    dm_wdata_i = 32'h77;
    step();
    chk("rst pre mem_req", 32'(mem_req_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst async mem_req", 32'(mem_req_o), 32'd0);
    chk("rst async stall_cnt", stall_cnt_o, 32'h0);
    chk("rst async mem_we", 32'(mem_we_o), 32'd0);
    clear_inputs();
    @(negedge clk);
    rst       = 1'b1;
    dm_req_i  = 1'b1;
    dm_addr_i = 32'h28;
    step();
    chk("rst after grant", mem_addr_o, 32'h28);
    chk("rst after cnt", stall_cnt_o, 32'd1);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h44;
    step();
    chk("rst after ready", 32'(dm_ready_o), 32'd1);
    chk("rst after rdata", dm_rdata_o, 32'h44);
    clear_inputs();
    step();

    // Counter saturation.
    dm_req_i  = 1'b1;
    dm_addr_i = 32'h30;
    step();
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("sat preload", stall_cnt_o, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sat c%0d", i), stall_cnt_o, 32'hFFFF_FFFF);
    end
    mem_ack_i = 1'b1;
    step();
    clear_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
